// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and imem.
// master: fetch side (req/addr out), slave: memory side (rvalid/rdata out).
interface if_fetch_stage_if #(
    parameter int WORD_WIDTH = 32
);
    logic                  req;
    logic [WORD_WIDTH-1:0] addr;
    logic                  rvalid;
    logic [WORD_WIDTH-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Instruction fetch + IF/ID register; one outstanding imem request.
// Ports: clk, rst (async low), freeze, branch_taken/branch_address,
// imem (master bus), pc/instruction/valid to ID.
// Optional macro IF_PERF_COUNTERS_EN adds fetched_count/squashed_count.
module if_fetch_stage #(
    parameter int                    WORD_WIDTH = 32,
    parameter logic [WORD_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  branch_taken,
    input  logic [WORD_WIDTH-1:0] branch_address,
    if_fetch_stage_if.master      imem,
    output logic [WORD_WIDTH-1:0] pc,
    output logic [WORD_WIDTH-1:0] instruction,
    output logic                  valid
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0]           fetched_count,
    output logic [31:0]           squashed_count
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SQUASH,
        HOLD
    } state_t;

    state_t state, state_n;

    logic [WORD_WIDTH-1:0] fetch_pc, fetch_pc_n;
    logic [WORD_WIDTH-1:0] req_addr, req_addr_n;
    logic [WORD_WIDTH-1:0] buf_pc, buf_pc_n;
    logic [WORD_WIDTH-1:0] buf_instr, buf_instr_n;
    logic [WORD_WIDTH-1:0] pc_n, instr_n;
    logic                  valid_n;
    logic                  load;
    logic                  drop;
    logic [WORD_WIDTH-1:0] req_inc;
    logic [WORD_WIDTH-1:0] target;

    assign req_inc   = req_addr + WORD_WIDTH'(4);
    assign target    = {branch_address[WORD_WIDTH-1:2], 2'b00};
    assign imem.req  = (state == REQ) || (state == SQUASH);
    assign imem.addr = req_addr;

    always_comb begin
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        req_addr_n  = req_addr;
        buf_pc_n    = buf_pc;
        buf_instr_n = buf_instr;
        pc_n        = pc;
        instr_n     = instruction;
        // Without freeze the slot empties unless something new loads.
        valid_n     = freeze ? valid : 1'b0;
        load        = 1'b0;
        drop        = 1'b0;

        if (branch_taken) begin
            pc_n       = '0;
            instr_n    = '0;
            valid_n    = 1'b0;
            fetch_pc_n = target;
            unique case (state)
                IDLE: begin
                    state_n    = REQ;
                    req_addr_n = target;
                end
                HOLD: begin
                    drop       = 1'b1;
                    state_n    = REQ;
                    req_addr_n = target;
                end
                REQ, SQUASH: begin
                    // An in-flight request must finish before the
                    // address may move; if it finishes now, drop it.
                    if (imem.rvalid) begin
                        drop       = 1'b1;
                        state_n    = REQ;
                        req_addr_n = target;
                    end else begin
                        state_n = SQUASH;
                    end
                end
                default: state_n = IDLE;
            endcase
        end else begin
            unique case (state)
                IDLE: begin
                    state_n    = REQ;
                    req_addr_n = fetch_pc;
                end
                REQ: begin
                    if (imem.rvalid) begin
                        if (freeze) begin
                            buf_pc_n    = req_inc;
                            buf_instr_n = imem.rdata;
                            state_n     = HOLD;
                        end else begin
                            pc_n       = req_inc;
                            instr_n    = imem.rdata;
                            valid_n    = 1'b1;
                            load       = 1'b1;
                            fetch_pc_n = req_inc;
                            req_addr_n = req_inc;
                        end
                    end
                end
                HOLD: begin
                    if (!freeze) begin
                        pc_n       = buf_pc;
                        instr_n    = buf_instr;
                        valid_n    = 1'b1;
                        load       = 1'b1;
                        fetch_pc_n = buf_pc;
                        req_addr_n = buf_pc;
                        state_n    = REQ;
                    end
                end
                SQUASH: begin
                    if (imem.rvalid) begin
                        drop       = 1'b1;
                        req_addr_n = fetch_pc;
                        state_n    = REQ;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            fetch_pc    <= RESET_PC;
            req_addr    <= RESET_PC;
            buf_pc      <= '0;
            buf_instr   <= '0;
            pc          <= '0;
            instruction <= '0;
            valid       <= 1'b0;
        end else begin
            state       <= state_n;
            fetch_pc    <= fetch_pc_n;
            req_addr    <= req_addr_n;
            buf_pc      <= buf_pc_n;
            buf_instr   <= buf_instr_n;
            pc          <= pc_n;
            instruction <= instr_n;
            valid       <= valid_n;
        end
    end

`ifdef IF_PERF_COUNTERS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_count  <= '0;
            squashed_count <= '0;
        end else begin
            if (load) fetched_count <= fetched_count + 32'd1;
            if (drop) squashed_count <= squashed_count + 32'd1;
        end
    end
`else
    logic unused_flags;
    assign unused_flags = load ^ drop;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: random memory latency,
// freeze and branches against a transaction-level fetch model.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_address = '0;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        valid;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] fetched_count;
    logic [31:0] squashed_count;
`endif

    if_fetch_stage_if #(.WORD_WIDTH(32)) bus ();

    if_fetch_stage #(
        .WORD_WIDTH(32),
        .RESET_PC  (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .freeze        (freeze),
        .branch_taken  (branch_taken),
        .branch_address(branch_address),
        .imem          (bus.master),
        .pc            (pc),
        .instruction   (instruction),
        .valid         (valid)
`ifdef IF_PERF_COUNTERS_EN
        ,
        .fetched_count (fetched_count),
        .squashed_count(squashed_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    exp_t q[$];

    int total = 0;
    int bad   = 0;

    // memory model
    int          lat       = 1;
    int          fixed_lat = 1;
    int          wait_cnt  = 0;
    logic [31:0] salt      = '0;

    // fetch model
    logic [31:0] exp_addr = '0;
    logic        stale    = 1'b0;

    // what happened in the cycle ending at the next rising edge
    logic        cycle_rst    = 1'b1;
    logic        cycle_freeze = 1'b0;
    logic        cycle_branch = 1'b0;
    logic        cycle_req    = 1'b0;
    logic        cycle_rvalid = 1'b0;
    logic [31:0] cycle_addr   = '0;

    logic [31:0] prev_pc    = '0;
    logic [31:0] prev_ins   = '0;
    logic        prev_valid = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int pick_lat();
        return (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 3));
    endfunction

    task automatic cycle(input logic f, input logic b,
                         input logic [31:0] t);
        logic       req;
        logic       rv;
        exp_t       e;
        @(negedge clk);
        freeze         = f;
        branch_taken   = b;
        branch_address = t;
        req = bus.req;
        rv  = req && (wait_cnt >= lat - 1);
        bus.rvalid = rv;
        bus.rdata  = rv ? (bus.addr ^ salt) : $urandom;
        cycle_rst    = 1'b0;
        cycle_freeze = f;
        cycle_branch = b;
        cycle_req    = req;
        cycle_rvalid = rv;
        cycle_addr   = bus.addr;
        if (b) begin
            q.delete();
            stale    = req && !rv;
            exp_addr = {t[31:2], 2'b00};
        end else if (req && rv) begin
            if (stale) begin
                stale = 1'b0;
            end else begin
                chk("imem_addr", bus.addr, exp_addr);
                e.pc  = bus.addr + 32'd4;
                e.ins = bus.addr ^ salt;
                q.push_back(e);
                exp_addr = exp_addr + 32'd4;
            end
        end
        @(posedge clk);
        if (req && rv) begin
            wait_cnt = 0;
            lat = pick_lat();
        end else if (req) begin
            wait_cnt++;
        end else begin
            wait_cnt = 0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst          = 1'b0;
        freeze       = 1'b0;
        branch_taken = 1'b0;
        bus.rvalid   = 1'b0;
        cycle_rst    = 1'b1;
        cycle_req    = 1'b0;
        cycle_rvalid = 1'b0;
        #1;
        chk("rst_req", 32'(bus.req), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_pc", pc, 32'd0);
        chk("rst_ins", instruction, 32'd0);
        chk("rst_addr", bus.addr, 32'd0);
        q.delete();
        stale    = 1'b0;
        exp_addr = 32'd0;
        wait_cnt = 0;
        @(negedge clk);
        rst        = 1'b1;
        // late response arriving in IDLE must be ignored
        bus.rvalid = 1'b1;
        bus.rdata  = 32'hDEADBEEF;
        @(posedge clk);
        #2;
        chk("idle_out_req", 32'(bus.req), 32'd1);
        chk("idle_out_addr", bus.addr, 32'd0);
        chk("idle_out_valid", 32'(valid), 32'd0);
    endtask

    // monitor: pops expectations whenever ID sees a fresh instruction
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst && !cycle_rst) begin
            if (cycle_branch) begin
                chk("flush_valid", 32'(valid), 32'd0);
                chk("flush_pc", pc, 32'd0);
                chk("flush_ins", instruction, 32'd0);
            end else if (cycle_freeze) begin
                chk("hold_pc", pc, prev_pc);
                chk("hold_ins", instruction, prev_ins);
                chk("hold_valid", 32'(valid), 32'(prev_valid));
            end else if (q.size() != 0) begin
                chk("deliver_valid", 32'(valid), 32'd1);
                if (valid) begin
                    e = q.pop_front();
                    chk("pc", pc, e.pc);
                    chk("instruction", instruction, e.ins);
                end
            end else begin
                chk("bubble_valid", 32'(valid), 32'd0);
            end
            if (cycle_req && !cycle_rvalid) begin
                chk("addr_stable", bus.addr, cycle_addr);
                chk("req_stable", 32'(bus.req), 32'd1);
            end
        end
        prev_pc    = pc;
        prev_ins   = instruction;
        prev_valid = valid;
    end

    initial begin
        bus.rvalid = 1'b0;
        bus.rdata  = '0;
        fixed_lat  = 1;
        lat        = 1;
        salt       = '0;
        do_reset();

        // 1-cycle memory echoing address
        cycle(0, 0, 0);
        #2;
        chk("first_valid", 32'(valid), 32'd1);
        chk("first_pc", pc, 32'd4);
        chk("first_ins", instruction, 32'd0);
        cycle(0, 0, 0);
        #2;
        chk("second_pc", pc, 32'd8);
        chk("second_ins", instruction, 32'd4);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);

        // 3-cycle latency
        fixed_lat = 3;
        lat       = 3;
        for (int i = 0; i < 12; i++) cycle(0, 0, 0);

        // freeze across a response
        fixed_lat = 1;
        lat       = 1;
        for (int i = 0; i < 10 && !bus.req; i++) cycle(0, 0, 0);
        cycle(1, 0, 0);
        #2;
        chk("hold_state_req", 32'(bus.req), 32'd0);
        for (int i = 0; i < 3; i++) cycle(1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);

        // branch while a 3-cycle request is outstanding
        fixed_lat = 3;
        lat       = 3;
        for (int i = 0; i < 10; i++) begin
            if (bus.req && wait_cnt == 0) break;
            cycle(0, 0, 0);
        end
        cycle(0, 1, 32'h103);
        #2;
        chk("squash_req", 32'(bus.req), 32'd1);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0);

        // branch together with rvalid and freeze
        fixed_lat = 1;
        lat       = 1;
        for (int i = 0; i < 10 && !bus.req; i++) cycle(0, 0, 0);
        cycle(1, 1, 32'h200);
        #2;
        chk("br_rv_req", 32'(bus.req), 32'd1);
        chk("br_rv_addr", bus.addr, 32'h200);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);

        // address wrap
        for (int i = 0; i < 10 && !bus.req; i++) cycle(0, 0, 0);
        cycle(0, 1, 32'hFFFF_FFF8);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        #2;
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_addr", bus.addr, 32'h0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);

        // random traffic
        fixed_lat = 0;
        for (int i = 0; i < 2000; i++) begin
            if (i % 200 == 0) salt = $urandom;
            cycle(($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 19) == 0),
                  $urandom);
        end

        // reset in the middle of a request
        fixed_lat = 3;
        lat       = 3;
        for (int i = 0; i < 12; i++) begin
            if (bus.req && wait_cnt == 1) break;
            cycle(0, 0, 0);
        end
        do_reset();
        salt = '0;
        for (int i = 0; i < 12; i++) cycle(0, 0, 0);

        // drain
        fixed_lat = 1;
        lat       = 1;
        for (int i = 0; i < 8; i++) cycle(0, 0, 0);
        #2;
        chk("drain", 32'(q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
